pim_cmd_scheduler: RTL and testbench
====================================

Name: pim_cmd_scheduler

Overview:
- Sits directly downstream of the request decoder.
- Takes one decoded request at a time (op, rank, bank-group, address) and expands it into timed DRAM/PIM commands: PRE, ACT, RD, WR, MOV, MAC, POOL.
- Uses an open-page policy with one open row per rank, and enforces tRP/tRCD/tCL/tWR plus PIM busy time with a single down-counter.
- Emits one command per cycle at most, and pulses done when a request retires.

Parameters:
- NUM_RANKS, 8, ranks tracked (rank_id 3 bits)
- ROW_W, 10, row field = addr[14:5]
- COL_W, 5, column field = addr[4:0]
- T_RP, 4, cycles from PRE to next ACT (same rank)
- T_RCD, 4, cycles from ACT to RD/WR
- T_CL, 5, cycles from RD to done
- T_WR, 4, cycles from WR to done
- T_PIM, 8, cycles from MOV/MAC/POOL to done

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low
- in_valid  in  1  request present
- in_ready  out  1  scheduler idle, can accept
- in_op  in  3  000 ld, 001 st, 010 ldst, 011 pre, 100 mac, 101 pool, others invalid
- in_rank  in  3  target rank
- in_bg  in  4  target bank group
- in_addr  in  15  {row, col}
- cmd  out  3  0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 MOV, 6 MAC, 7 POOL
- cmd_rank  out  3  rank of cmd
- cmd_bg  out  4  bank group of cmd
- cmd_row  out  10  row (valid with ACT)
- cmd_col  out  5  column (valid with RD/WR)
- done  out  1  one-cycle retire pulse
- err  out  1  one-cycle pulse, invalid op retired

Behaviour:
- Reset (async, reset=0):
  - state IDLE, counter 0, all open_valid[r]=0.
  - cmd=NOP; cmd_rank/bg/row/col=0; done=0; err=0; in_ready=1.
  - Reset mid-operation abandons the request with no done pulse and closes all rows.
- in_ready = (state==IDLE), driven combinationally from state. The request is accepted on a clk edge where in_valid && in_ready, and is latched into a request register. Inputs are ignored while busy.
- All outputs are registered. cmd is NOP in every cycle without an issue, so each command is a one-cycle pulse.
- States: IDLE, DISPATCH, PRE, WAIT_RP, ACT, WAIT_RCD, RW, WAIT_DONE.
- DISPATCH (cycle after accept) decodes the request:
  - ld/st, row hit (open_valid[rank] && open_row[rank]==row): go to RW.
  - ld/st, rank closed: go to ACT.
  - ld/st, row conflict: go to PRE.
  - op 011, rank open: go to PRE, then retire; open_valid cleared.
  - op 011, rank closed: retire immediately (done, no cmd).
  - ldst/mac/pool: issue MOV/MAC/POOL this cycle and load the counter with T_PIM-1, go to WAIT_DONE. Rank row state is unchanged.
  - Invalid op: done=1 and err=1 this cycle, return to IDLE.
- DISPATCH issues the hit RD/WR directly (no extra cycle), so a row-hit read has cmd=RD in the cycle after accept.
- PRE:
  - Issue PRE; clear open_valid[rank]; load counter T_RP-1; go to WAIT_RP.
  - WAIT_RP exits when counter==0: to ACT for ld/st, or retire (done) for op 011.
- ACT:
  - Issue ACT with cmd_row; set open_valid/open_row[rank]; load counter T_RCD-1; go to WAIT_RCD.
  - WAIT_RCD exits to RW when counter==0.
- RW:
  - Issue RD (ld) or WR (st) with cmd_col; load counter T_CL-1 or T_WR-1; go to WAIT_DONE.
- WAIT_DONE: when counter==0, done=1 and return to IDLE. The next request can be accepted on the edge following done.
- Timing relations: command spacing ACT→RD is exactly T_RCD cycles and PRE→ACT is exactly T_RP. done is exactly T_CL/T_WR/T_PIM cycles after the RD/WR/PIM command.
- Counter width is clog2(max timing parameter)+1 bits. Each T_* parameter must be ≥1. A value of 1 means the exit happens the cycle after issue.

Decomposition:
- Shared package pim_pkg holds:
  - op encodings (OP_LD…OP_POOL), cmd encodings (CMD_NOP…CMD_POOL), state enum;
  - ROW_W/COL_W field slicing constants and default timing constants.
- One natural sub-module, pim_open_row_table: per-rank valid+row register file with lookup (hit/conflict) and set/clear ports, reset-cleared.

Test Plan:
- After reset: ld rank 2 addr 0x0043 (row 2, col 3) → ACT rank2 row2 in cycle 2 after accept; RD col3 4 cycles later; done 5 cycles after RD; open_row[2]=2.
- Same ld again → RD in cycle 1 after accept (row hit, no ACT); done 5 cycles later.
- st rank 2 row 7 → PRE, ACT 4 cycles later with row 7, WR 4 cycles later, done 4 cycles after WR.
- op 011 on rank 2 (open) → PRE, done 4 cycles later, open_valid[2]=0. op 011 on rank 5 (closed) → done in DISPATCH cycle with cmd NOP throughout.
- mac rank 1, then pool while busy → MAC issued, in_ready=0 for T_PIM cycles, pool held off and accepted on the edge after done.
- Invalid op 111 → done=1 and err=1 together, single pulse. Assert reset during WAIT_RCD → all outputs 0 immediately, no done, next ld to the same rank issues ACT.

Source files
------------

// File: rtl/pim_pkg.sv
// Shared encodings, field widths and default timing for the PIM command scheduler.
package pim_pkg;

    // Request field geometry and default array size
    localparam int NUM_RANKS_DEF = 8;
    localparam int ROW_W_DEF     = 10;
    localparam int COL_W_DEF     = 5;
    localparam int BG_W          = 4;

    // Default timing, in clk cycles
    localparam int T_RP_DEF  = 4;
    localparam int T_RCD_DEF = 4;
    localparam int T_CL_DEF  = 5;
    localparam int T_WR_DEF  = 4;
    localparam int T_PIM_DEF = 8;

    // Request opcodes; 110 and 111 are invalid and retire with err
    localparam logic [2:0] OP_LD   = 3'b000;
    localparam logic [2:0] OP_ST   = 3'b001;
    localparam logic [2:0] OP_LDST = 3'b010;
    localparam logic [2:0] OP_PRE  = 3'b011;
    localparam logic [2:0] OP_MAC  = 3'b100;
    localparam logic [2:0] OP_POOL = 3'b101;

    typedef enum logic [2:0] {
        CMD_NOP  = 3'd0,
        CMD_ACT  = 3'd1,
        CMD_RD   = 3'd2,
        CMD_WR   = 3'd3,
        CMD_PRE  = 3'd4,
        CMD_MOV  = 3'd5,
        CMD_MAC  = 3'd6,
        CMD_POOL = 3'd7
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DISPATCH,
        ST_PRE,
        ST_WAIT_RP,
        ST_ACT,
        ST_WAIT_RCD,
        ST_RW,
        ST_WAIT_DONE
    } state_e;

    // Largest of the timing values; sizes the shared down-counter
    function automatic int max_timing(input int a, input int b, input int c,
                                      input int d, input int e);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        return m;
    endfunction

endpackage

// File: rtl/pim_open_row_table.sv
// Per-rank open-row tracker: one valid bit and one row address per rank,
// with a combinational lookup and single set/clear update ports.
module pim_open_row_table
    import pim_pkg::*;
#(
    parameter int NUM_RANKS = NUM_RANKS_DEF,
    parameter int ROW_W     = ROW_W_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [$clog2(NUM_RANKS)-1:0] lk_rank,
    input  logic [ROW_W-1:0]             lk_row,
    output logic                         lk_open,
    output logic                         lk_hit,
    input  logic                         set_en,
    input  logic [$clog2(NUM_RANKS)-1:0] set_rank,
    input  logic [ROW_W-1:0]             set_row,
    input  logic                         clr_en,
    input  logic [$clog2(NUM_RANKS)-1:0] clr_rank
);

    localparam int RANK_W = $clog2(NUM_RANKS);

    logic [NUM_RANKS-1:0] valid_reg;
    logic [ROW_W-1:0]     row_reg [NUM_RANKS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RANKS; gi++) begin : g_rank
            // One entry per rank; an ACT opens a row, a PRE closes it
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    valid_reg[gi] <= 1'b0;
                    row_reg[gi]   <= '0;
                end else if (set_en && set_rank == RANK_W'(gi)) begin
                    valid_reg[gi] <= 1'b1;
                    row_reg[gi]   <= set_row;
                end else if (clr_en && clr_rank == RANK_W'(gi)) begin
                    valid_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    // A hit needs the rank open on exactly the requested row
    always_comb begin
        lk_open = valid_reg[lk_rank];
        lk_hit  = valid_reg[lk_rank] && (row_reg[lk_rank] == lk_row);
    end

endmodule

// File: rtl/pim_cmd_scheduler.sv
// Expands one decoded request at a time into timed DRAM/PIM commands using an
// open-page policy (one open row per rank) and a single shared down-counter.
module pim_cmd_scheduler
    import pim_pkg::*;
#(
    parameter int NUM_RANKS = NUM_RANKS_DEF,
    parameter int ROW_W     = ROW_W_DEF,
    parameter int COL_W     = COL_W_DEF,
    parameter int T_RP      = T_RP_DEF,
    parameter int T_RCD     = T_RCD_DEF,
    parameter int T_CL      = T_CL_DEF,
    parameter int T_WR      = T_WR_DEF,
    parameter int T_PIM     = T_PIM_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [2:0]                   in_op,
    input  logic [$clog2(NUM_RANKS)-1:0] in_rank,
    input  logic [BG_W-1:0]              in_bg,
    input  logic [ROW_W+COL_W-1:0]       in_addr,
    output logic [2:0]                   cmd,
    output logic [$clog2(NUM_RANKS)-1:0] cmd_rank,
    output logic [BG_W-1:0]              cmd_bg,
    output logic [ROW_W-1:0]             cmd_row,
    output logic [COL_W-1:0]             cmd_col,
    output logic                         done,
    output logic                         err
);

    localparam int RANK_W = $clog2(NUM_RANKS);
    localparam int CNT_W  = $clog2(max_timing(T_RP, T_RCD, T_CL, T_WR, T_PIM)) + 1;

    // Counter reload values: a wait of T cycles counts T-1 down to 0
    localparam logic [CNT_W-1:0] CNT_RP  = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0] CNT_RCD = CNT_W'(T_RCD - 1);
    localparam logic [CNT_W-1:0] CNT_CL  = CNT_W'(T_CL - 1);
    localparam logic [CNT_W-1:0] CNT_WR  = CNT_W'(T_WR - 1);
    localparam logic [CNT_W-1:0] CNT_PIM = CNT_W'(T_PIM - 1);

    state_e              state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;

    logic [2:0]          req_op_reg;
    logic [RANK_W-1:0]   req_rank_reg;
    logic [BG_W-1:0]     req_bg_reg;
    logic [ROW_W-1:0]    req_row_reg;
    logic [COL_W-1:0]    req_col_reg;

    cmd_e                cmd_reg, cmd_next;
    logic [RANK_W-1:0]   cmd_rank_reg, cmd_rank_next;
    logic [BG_W-1:0]     cmd_bg_reg, cmd_bg_next;
    logic [ROW_W-1:0]    cmd_row_reg, cmd_row_next;
    logic [COL_W-1:0]    cmd_col_reg, cmd_col_next;
    logic                done_reg, done_next;
    logic                err_reg, err_next;

    cmd_e                rw_cmd;
    logic [CNT_W-1:0]    rw_cnt;
    logic                row_open, row_hit;
    logic                tbl_set, tbl_clr;

    assign in_ready = (state_reg == ST_IDLE);

    pim_open_row_table #(
        .NUM_RANKS (NUM_RANKS),
        .ROW_W     (ROW_W)
    ) u_open_rows (
        .clk      (clk),
        .reset    (reset),
        .lk_rank  (req_rank_reg),
        .lk_row   (req_row_reg),
        .lk_open  (row_open),
        .lk_hit   (row_hit),
        .set_en   (tbl_set),
        .set_rank (req_rank_reg),
        .set_row  (req_row_reg),
        .clr_en   (tbl_clr),
        .clr_rank (req_rank_reg)
    );

    // The row table follows the commands as they are issued
    assign tbl_set = (cmd_next == CMD_ACT);
    assign tbl_clr = (cmd_next == CMD_PRE);

    // Capture the request on acceptance; it stays stable until retirement
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_op_reg   <= '0;
            req_rank_reg <= '0;
            req_bg_reg   <= '0;
            req_row_reg  <= '0;
            req_col_reg  <= '0;
        end else if (in_valid && in_ready) begin
            req_op_reg   <= in_op;
            req_rank_reg <= in_rank;
            req_bg_reg   <= in_bg;
            req_row_reg  <= in_addr[ROW_W+COL_W-1:COL_W];
            req_col_reg  <= in_addr[COL_W-1:0];
        end
    end

    // Next-state and next-output decode. The last cycle of each wait issues the
    // following command itself, so command spacing equals the T_* value exactly;
    // this is also why the RW state is normally bypassed.
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        cmd_next      = CMD_NOP;
        done_next     = 1'b0;
        err_next      = 1'b0;
        cmd_rank_next = '0;
        cmd_bg_next   = '0;
        cmd_row_next  = '0;
        cmd_col_next  = '0;
        rw_cmd        = (req_op_reg == OP_ST) ? CMD_WR : CMD_RD;
        rw_cnt        = (req_op_reg == OP_ST) ? CNT_WR : CNT_CL;

        case (state_reg)
            ST_IDLE: begin
                if (in_valid) state_next = ST_DISPATCH;
            end
            ST_DISPATCH: begin
                case (req_op_reg)
                    OP_LD, OP_ST: begin
                        if (row_hit) begin
                            cmd_next   = rw_cmd;
                            cnt_next   = rw_cnt;
                            state_next = ST_WAIT_DONE;
                        end else if (row_open) begin
                            state_next = ST_PRE;
                        end else begin
                            state_next = ST_ACT;
                        end
                    end
                    OP_PRE: begin
                        if (row_open) begin
                            state_next = ST_PRE;
                        end else begin
                            done_next  = 1'b1;
                            state_next = ST_IDLE;
                        end
                    end
                    OP_LDST: begin
                        cmd_next   = CMD_MOV;
                        cnt_next   = CNT_PIM;
                        state_next = ST_WAIT_DONE;
                    end
                    OP_MAC: begin
                        cmd_next   = CMD_MAC;
                        cnt_next   = CNT_PIM;
                        state_next = ST_WAIT_DONE;
                    end
                    OP_POOL: begin
                        cmd_next   = CMD_POOL;
                        cnt_next   = CNT_PIM;
                        state_next = ST_WAIT_DONE;
                    end
                    default: begin
                        done_next  = 1'b1;
                        err_next   = 1'b1;
                        state_next = ST_IDLE;
                    end
                endcase
            end
            ST_PRE: begin
                cmd_next   = CMD_PRE;
                cnt_next   = CNT_RP;
                state_next = ST_WAIT_RP;
            end
            ST_WAIT_RP: begin
                if (cnt_reg == '0) begin
                    if (req_op_reg == OP_PRE) begin
                        done_next  = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        cmd_next   = CMD_ACT;
                        cnt_next   = CNT_RCD;
                        state_next = ST_WAIT_RCD;
                    end
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            ST_ACT: begin
                cmd_next   = CMD_ACT;
                cnt_next   = CNT_RCD;
                state_next = ST_WAIT_RCD;
            end
            ST_WAIT_RCD: begin
                if (cnt_reg == '0) begin
                    cmd_next   = rw_cmd;
                    cnt_next   = rw_cnt;
                    state_next = ST_WAIT_DONE;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            ST_RW: begin
                cmd_next   = rw_cmd;
                cnt_next   = rw_cnt;
                state_next = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (cnt_reg == '0) begin
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Address fields are driven only alongside the command that uses them
        if (cmd_next != CMD_NOP) begin
            cmd_rank_next = req_rank_reg;
            cmd_bg_next   = req_bg_reg;
        end
        if (cmd_next == CMD_ACT) cmd_row_next = req_row_reg;
        if (cmd_next == CMD_RD || cmd_next == CMD_WR) cmd_col_next = req_col_reg;
    end

    // State, counter and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            cmd_reg      <= CMD_NOP;
            cmd_rank_reg <= '0;
            cmd_bg_reg   <= '0;
            cmd_row_reg  <= '0;
            cmd_col_reg  <= '0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            cmd_reg      <= cmd_next;
            cmd_rank_reg <= cmd_rank_next;
            cmd_bg_reg   <= cmd_bg_next;
            cmd_row_reg  <= cmd_row_next;
            cmd_col_reg  <= cmd_col_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
        end
    end

    assign cmd      = cmd_reg;
    assign cmd_rank = cmd_rank_reg;
    assign cmd_bg   = cmd_bg_reg;
    assign cmd_row  = cmd_row_reg;
    assign cmd_col  = cmd_col_reg;
    assign done     = done_reg;
    assign err      = err_reg;

endmodule

// File: tb/tb_pim_cmd_scheduler.sv
// Self-checking bench: a transaction-level timing model predicts every output
// per cycle; directed test-plan cases pin the model with literal expectations.
module tb_pim_cmd_scheduler;

    localparam int T_RP  = 4;
    localparam int T_RCD = 4;
    localparam int T_CL  = 5;
    localparam int T_WR  = 4;
    localparam int T_PIM = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = '0;
    logic [2:0]  in_rank = '0;
    logic [3:0]  in_bg = '0;
    logic [14:0] in_addr = '0;
    logic [2:0]  cmd;
    logic [2:0]  cmd_rank;
    logic [3:0]  cmd_bg;
    logic [9:0]  cmd_row;
    logic [4:0]  cmd_col;
    logic        done;
    logic        err;

    pim_cmd_scheduler dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_op    (in_op),
        .in_rank  (in_rank),
        .in_bg    (in_bg),
        .in_addr  (in_addr),
        .cmd      (cmd),
        .cmd_rank (cmd_rank),
        .cmd_bg   (cmd_bg),
        .cmd_row  (cmd_row),
        .cmd_col  (cmd_col),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Edge counter: value k means "outputs visible after the k-th rising edge"
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Expected outputs keyed by edge index (absent entry = idle/NOP/zero)
    int e_cmd[int];
    int e_rank[int];
    int e_bg[int];
    int e_row[int];
    int e_col[int];
    int e_done[int];
    int e_err[int];
    int e_busy[int];

    // Model of the open-row state and when the scheduler is free again
    bit mvalid[8];
    int mrow[8];
    int free_edge = 0;

    task automatic check(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", nm, cyc, got, want);
        end
    endtask

    function automatic void put_cmd(input int c, input int cm, input int rk,
                                    input int b, input int rw, input int cl);
        e_cmd[c]  = cm;
        e_rank[c] = rk;
        e_bg[c]   = b;
        e_row[c]  = rw;
        e_col[c]  = cl;
    endfunction

    // Transaction model: from the accept edge, place every command/done at its
    // absolute offset and mark the busy window. Returns the done offset.
    function automatic int sched(input int acc, input int op, input int r,
                                 input int b, input int row, input int col);
        int k;
        int rwc;
        int tl;
        case (op)
            0, 1: begin
                rwc = (op == 0) ? 2 : 3;
                tl  = (op == 0) ? T_CL : T_WR;
                if (mvalid[r] && mrow[r] == row) begin
                    k = 1;
                end else begin
                    k = 2;
                    if (mvalid[r]) begin
                        put_cmd(acc + 2, 4, r, b, 0, 0);
                        k = 2 + T_RP;
                    end
                    put_cmd(acc + k, 1, r, b, row, 0);
                    mvalid[r] = 1'b1;
                    mrow[r]   = row;
                    k = k + T_RCD;
                end
                put_cmd(acc + k, rwc, r, b, 0, col);
                k = k + tl;
            end
            3: begin
                if (mvalid[r]) begin
                    put_cmd(acc + 2, 4, r, b, 0, 0);
                    mvalid[r] = 1'b0;
                    k = 2 + T_RP;
                end else begin
                    k = 1;
                end
            end
            2, 4, 5: begin
                put_cmd(acc + 1, (op == 2) ? 5 : (op == 4) ? 6 : 7, r, b, 0, 0);
                k = 1 + T_PIM;
            end
            default: begin
                k = 1;
                e_err[acc + 1] = 1;
            end
        endcase
        e_done[acc + k] = 1;
        for (int i = 0; i < k; i++) e_busy[acc + i] = 1;
        free_edge = acc + k + 1;
        return k;
    endfunction

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("cmd",      int'(cmd),      e_cmd.exists(cyc)  ? e_cmd[cyc]  : 0);
            check("cmd_rank", int'(cmd_rank), e_rank.exists(cyc) ? e_rank[cyc] : 0);
            check("cmd_bg",   int'(cmd_bg),   e_bg.exists(cyc)   ? e_bg[cyc]   : 0);
            check("cmd_row",  int'(cmd_row),  e_row.exists(cyc)  ? e_row[cyc]  : 0);
            check("cmd_col",  int'(cmd_col),  e_col.exists(cyc)  ? e_col[cyc]  : 0);
            check("done",     int'(done),     e_done.exists(cyc) ? 1 : 0);
            check("err",      int'(err),      e_err.exists(cyc)  ? 1 : 0);
            check("in_ready", int'(in_ready), e_busy.exists(cyc) ? 0 : 1);
        end
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Present a request (after lead idle cycles), hold it until the model says
    // it is accepted, and record the expected schedule.
    task automatic do_req(input int op, input int r, input int b, input int row,
                          input int col, input int lead, output int acc);
        int k;
        logic [9:0] row_v;
        logic [4:0] col_v;
        in_valid = 1'b0;
        repeat (lead) @(negedge clk);
        row_v    = row[9:0];
        col_v    = col[4:0];
        in_op    = op[2:0];
        in_rank  = r[2:0];
        in_bg    = b[3:0];
        in_addr  = {row_v, col_v};
        in_valid = 1'b1;
        acc = (cyc + 1 > free_edge) ? cyc + 1 : free_edge;
        k = sched(acc, op, r, b, row, col);
        $display("req op=%0d rank=%0d bg=%0d row=%0d col=%0d accept_edge=%0d done_offset=%0d",
                 op, r, b, row, col, acc, k);
        wait_cyc(acc);
        in_valid = 1'b0;
        in_op    = 3'($urandom);
        in_rank  = 3'($urandom);
        in_bg    = 4'($urandom);
        in_addr  = 15'($urandom);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a;
        int p;
        int sel;
        int op;

        // Reset state
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cmd", int'(cmd), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_ready", int'(in_ready), 1);
        check("rst_row", int'(cmd_row), 0);
        reset = 1'b1;
        free_edge = cyc + 1;
        chk_en = 1'b1;

        // ld rank 2 addr 0x0043 on a closed rank
        do_req(0, 2, 1, 2, 3, 0, a);
        wait_cyc(a + 2);
        check("t1_act", int'(cmd), 1);
        check("t1_act_row", int'(cmd_row), 2);
        check("t1_act_rank", int'(cmd_rank), 2);
        wait_cyc(a + 6);
        check("t1_rd", int'(cmd), 2);
        check("t1_rd_col", int'(cmd_col), 3);
        wait_cyc(a + 11);
        check("t1_done", int'(done), 1);

        // Same ld again: row hit
        do_req(0, 2, 1, 2, 3, 0, a);
        wait_cyc(a + 1);
        check("t2_rd_hit", int'(cmd), 2);
        wait_cyc(a + 6);
        check("t2_done", int'(done), 1);

        // st rank 2 row 7: conflict
        do_req(1, 2, 3, 7, 1, 1, a);
        wait_cyc(a + 2);
        check("t3_pre", int'(cmd), 4);
        wait_cyc(a + 6);
        check("t3_act", int'(cmd), 1);
        check("t3_act_row", int'(cmd_row), 7);
        wait_cyc(a + 10);
        check("t3_wr", int'(cmd), 3);
        wait_cyc(a + 14);
        check("t3_done", int'(done), 1);

        // Precharge open rank 2, then closed rank 5
        do_req(3, 2, 0, 0, 0, 0, a);
        wait_cyc(a + 2);
        check("t4_pre", int'(cmd), 4);
        wait_cyc(a + 6);
        check("t4_done", int'(done), 1);
        do_req(3, 5, 0, 0, 0, 0, a);
        wait_cyc(a + 1);
        check("t5_done", int'(done), 1);
        check("t5_cmd_nop", int'(cmd), 0);

        // mac on rank 1, pool presented while busy
        do_req(4, 1, 2, 0, 0, 0, a);
        wait_cyc(a + 1);
        check("t6_mac", int'(cmd), 6);
        check("t6_busy", int'(in_ready), 0);
        do_req(5, 1, 2, 0, 0, 0, p);
        check("t6_pool_accept_edge", p, a + 10);
        wait_cyc(p + 1);
        check("t6_pool", int'(cmd), 7);

        // Invalid op
        do_req(7, 0, 0, 0, 0, 0, a);
        wait_cyc(a + 1);
        check("t7_done", int'(done), 1);
        check("t7_err", int'(err), 1);
        wait_cyc(a + 2);
        check("t7_err_pulse", int'(err), 0);

        // Randomized traffic over a few ranks/rows to mix hits, misses, conflicts
        for (int n = 0; n < 80; n++) begin
            sel = $urandom_range(0, 15);
            if (sel < 5)       op = 0;
            else if (sel < 9)  op = 1;
            else if (sel == 9) op = 2;
            else if (sel == 10) op = 3;
            else if (sel == 11) op = 4;
            else if (sel == 12) op = 5;
            else               op = $urandom_range(6, 7);
            do_req(op, $urandom_range(0, 3), $urandom_range(0, 15),
                   $urandom_range(0, 2), $urandom_range(0, 31),
                   $urandom_range(0, 2), a);
        end

        // Reset during WAIT_RCD
        do_req(3, 4, 0, 0, 0, 0, a);
        do_req(0, 4, 2, 9, 5, 0, a);
        wait_cyc(a + 3);
        chk_en = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("mid_rst_cmd", int'(cmd), 0);
        check("mid_rst_done", int'(done), 0);
        check("mid_rst_rank", int'(cmd_rank), 0);
        check("mid_rst_ready", int'(in_ready), 1);
        repeat (8) begin
            @(negedge clk);
            check("mid_rst_no_done", int'(done), 0);
        end
        reset = 1'b1;
        e_cmd.delete();
        e_rank.delete();
        e_bg.delete();
        e_row.delete();
        e_col.delete();
        e_done.delete();
        e_err.delete();
        e_busy.delete();
        for (int i = 0; i < 8; i++) mvalid[i] = 1'b0;
        free_edge = cyc + 1;
        @(negedge clk);
        chk_en = 1'b1;
        do_req(0, 4, 2, 9, 5, 0, a);
        wait_cyc(a + 2);
        check("post_rst_act", int'(cmd), 1);
        check("post_rst_row", int'(cmd_row), 9);
        wait_cyc(free_edge + 2);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
